// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad entry block.
package keypad_pkg;

  // Scan frame classification
  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_KEY   = 2'd1,
    CLS_MULTI = 2'd2
  } key_cls_e;

  // Frame class plus key code; code is zero unless cls is CLS_KEY
  typedef struct packed {
    key_cls_e   cls;
    logic [3:0] code;
  } key_class_t;

  localparam key_class_t CLASS_NONE = '{cls: CLS_NONE, code: 4'h0};

  // Command keys
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_MODE  = 4'hD;
  localparam logic [3:0] KEY_SET   = 4'hE;
  localparam logic [3:0] KEY_START = 4'hF;

  // Key legend indexed by row*4+col
  localparam logic [0:15][3:0] KEY_MAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_entry_scan.sv
// Column scanner: row synchronizer, column drive, dwell timing and frame capture.
module keypad_entry_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      row,
  output logic [3:0]      col,
  output logic [3:0][3:0] frame,
  output logic            frame_done
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;

  // Two-flop synchronizer on the pulled-up row lines (idle high)
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Dwell on each column, capture pressed rows at the end, then rotate
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      dwell      <= '0;
      frame      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (dwell == LAST) begin
        dwell          <= '0;
        frame[col_idx] <= ~row_sync;
        col_idx        <= col_idx + 2'd1;
        col            <= {col[2:0], col[3]};
        frame_done     <= (col_idx == 2'd3);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Hex keypad entry: classifies scan frames, debounces them and assembles a 4-digit value.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] value,
  output logic        set,
  output logic        start,
  output logic [1:0]  mode,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0][3:0] frame;
  logic            frame_done;
  logic [4:0]      hits;
  logic [3:0]      hit_code;
  key_class_t      cls_now;
  key_class_t      cand;
  key_class_t      cand_next;
  key_class_t      stable;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            press;
  logic [3:0]      press_code;

  keypad_entry_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .frame      (frame),
    .frame_done (frame_done)
  );

  // Classify the captured frame by number of pressed keys
  always_comb begin
    hits     = 5'd0;
    hit_code = 4'h0;
    cls_now  = CLASS_NONE;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (frame[c][r]) begin
          hits     = hits + 5'd1;
          hit_code = KEY_MAP[4'(r * 4 + c)];
        end
      end
    end
    if (hits == 5'd1) begin
      cls_now = '{cls: CLS_KEY, code: hit_code};
    end else if (hits >= 5'd2) begin
      cls_now = '{cls: CLS_MULTI, code: 4'h0};
    end
  end

  // Next candidate and saturating agreement count
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (cls_now == cand) begin
      if (cnt != CW'(DEBOUNCE_CNT)) begin
        cnt_next = cnt + CW'(1);
      end
    end else begin
      cand_next = cls_now;
      cnt_next  = CW'(1);
    end
  end

  // Debounce once per frame; flag a press on a stable NONE -> KEY step
  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= CLASS_NONE;
      cnt        <= '0;
      stable     <= CLASS_NONE;
      press      <= 1'b0;
      press_code <= 4'h0;
    end else begin
      press <= 1'b0;
      if (frame_done) begin
        cand <= cand_next;
        cnt  <= cnt_next;
        if (cnt_next == CW'(DEBOUNCE_CNT)) begin
          stable     <= cand_next;
          press      <= (stable.cls == CLS_NONE) && (cand_next.cls == CLS_KEY);
          press_code <= cand_next.code;
        end
      end
    end
  end

  // Apply an accepted key: shift in digits or execute a command
  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= 16'h0000;
      mode      <= 2'b00;
      set       <= 1'b0;
      start     <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= press;
      set       <= 1'b0;
      start     <= 1'b0;
      if (press) begin
        key_code <= press_code;
        case (press_code)
          KEY_CLEAR: value <= 16'h0000;
          KEY_MODE:  mode  <= mode + 2'd1;
          KEY_SET:   set   <= 1'b1;
          KEY_START: start <= 1'b1;
          default:   value <= {value[11:0], press_code};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry with a frame-level reference model.
module tb_keypad_entry;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 2;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
    logic [1:0]  mode;
    logic        set;
    logic        start;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] value;
  logic        set;
  logic        start;
  logic [1:0]  mode;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] keys;

  int   cyc;
  int   checks;
  int   failures;
  int   kv_count;
  exp_t sb[$];

  string legend = "123A456B789C0FED";

  // reference model state: class -1 = none, -2 = multi, 0..15 = key code
  int          m_cand;
  int          m_cnt;
  int          m_stable;
  logic [15:0] m_value;
  logic [1:0]  m_mode;
  logic [15:0] snap_prev_value, snap_cur_value;
  logic [1:0]  snap_prev_mode, snap_cur_mode;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .value     (value),
    .set       (set),
    .start     (start),
    .mode      (mode),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (keys[r * 4 + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hexval(input byte ch);
    if (ch >= "0" && ch <= "9") return int'(ch - "0");
    return int'(ch - "A") + 10;
  endfunction

  function automatic logic [15:0] key_bit(input int k);
    for (int i = 0; i < 16; i++) begin
      if (hexval(legend[i]) == k) return 16'(1) << i;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_cand = -1; m_cnt = 0; m_stable = -1;
    m_value = 16'h0; m_mode = 2'd0;
    snap_prev_value = 16'h0; snap_cur_value = 16'h0;
    snap_prev_mode = 2'd0; snap_cur_mode = 2'd0;
  endtask

  // One frame of the reference model; s = cycle at which the frame began
  task automatic model_step(input logic [15:0] k, input int s);
    int   n;
    int   cls;
    exp_t e;
    n = $countones(k);
    cls = (n == 0) ? -1 : -2;
    if (n == 1) begin
      for (int i = 0; i < 16; i++) if (k[i]) cls = hexval(legend[i]);
    end
    if (cls == m_cand) begin
      if (m_cnt < DB) m_cnt++;
    end else begin
      m_cand = cls;
      m_cnt = 1;
    end
    if (m_cnt >= DB) begin
      if (m_stable == -1 && m_cand >= 0) begin
        if (m_cand <= 11) m_value = {m_value[11:0], 4'(m_cand)};
        else if (m_cand == 12) m_value = 16'h0;
        else if (m_cand == 13) m_mode = m_mode + 2'd1;
        e.code  = 4'(m_cand);
        e.value = m_value;
        e.mode  = m_mode;
        e.set   = (m_cand == 14);
        e.start = (m_cand == 15);
        e.cyc   = s + int'(FRAME) + 2;
        sb.push_back(e);
      end
      m_stable = m_cand;
    end
  endtask

  task automatic wait_frame_start(output int s);
    logic [3:0] prev;
    bit found;
    prev = col;
    found = 0;
    for (int i = 0; i < 4 * int'(FRAME) && !found; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && prev == 4'b0111) found = 1;
      else prev = col;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL frame_start_timeout actual col=%b expected a 0111->1110 step", col);
    end
    s = cyc;
  endtask

  // Present one key set for exactly one scan frame
  task automatic run_frame(input logic [15:0] k);
    int s;
    wait_frame_start(s);
    chk("value_hold", value, snap_prev_value);
    chk("mode_hold", mode, snap_prev_mode);
    keys = k;
    model_step(k, s);
    snap_prev_value = snap_cur_value;
    snap_prev_mode  = snap_cur_mode;
    snap_cur_value  = m_value;
    snap_cur_mode   = m_mode;
  endtask

  task automatic press(input int k, input int hold, input int rel);
    repeat (hold) run_frame(key_bit(k));
    repeat (rel) run_frame(16'h0);
  endtask

  // Monitor: every key_valid pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (key_valid) begin
        kv_count++;
        if (sb.size() == 0) begin
          chk("unexpected_key_valid", key_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("key_code", key_code, e.code);
          chk("event_value", value, e.value);
          chk("event_mode", mode, e.mode);
          chk("set", set, e.set);
          chk("start", start, e.start);
          chk("event_cycle", cyc, e.cyc);
        end
      end else if (set || start) begin
        chk("set_without_key", set, 0);
        chk("start_without_key", start, 0);
      end
    end
  end

  initial begin
    int k0;
    int a, b;
    cyc = 0; checks = 0; failures = 0; kv_count = 0;
    keys = 16'h0;
    rst = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_value", value, 16'h0);
    chk("rst_mode", mode, 0);
    chk("rst_pulses", {key_valid, set, start}, 0);
    chk("rst_key_code", key_code, 0);
    rst = 1'b0;

    // digit entry
    press(1, 3, 3); press(2, 3, 3); press(10, 3, 3); press(7, 3, 3);
    chk("value_12A7", value, 16'h12A7);
    press(5, 3, 3);
    chk("value_2A75", value, 16'h2A75);

    // commands
    press(14, 3, 3);
    chk("value_after_set", value, 16'h2A75);
    press(15, 3, 3);
    repeat (5) press(13, 3, 3);
    chk("mode_after_5", mode, 1);
    press(12, 3, 3);
    chk("value_clear", value, 16'h0);

    // bounce then long hold
    k0 = kv_count;
    run_frame(key_bit(3)); run_frame(16'h0); run_frame(key_bit(3)); run_frame(16'h0);
    press(3, 20, 3);
    chk("bounce_events", kv_count - k0, 1);
    chk("bounce_value", value, 16'h0003);

    // multi-key
    k0 = kv_count;
    repeat (3) run_frame(key_bit(4) | key_bit(8));
    repeat (3) run_frame(key_bit(4));
    repeat (3) run_frame(16'h0);
    chk("multi_events", kv_count - k0, 0);
    press(4, 3, 3);
    chk("multi_then_4", kv_count - k0, 1);

    // randomized segments
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)
        repeat (int'($urandom_range(1, 3))) run_frame(key_bit(a) | key_bit(b));
      else
        press(a, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end
    repeat (3) run_frame(16'h0);
    chk("sb_drained_random", sb.size(), 0);

    // reset mid-scan
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_col", col, 4'b1110);
    chk("midrst_value", value, 16'h0);
    chk("midrst_mode", mode, 0);
    chk("midrst_pulses", {key_valid, set, start}, 0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("col_before_capture", col, 4'b1110);
    @(negedge clk);
    chk("col_first_capture", col, 4'b1101);

    // key 9 after reset
    press(9, 3, 3);
    chk("value_9", value, 16'h0009);
    chk("sb_drained_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
